mips32_boot_ctrl: RTL and testbench
===================================

# mips32_boot_ctrl

Single-clock boot-and-run sequencer for the pipelined MIPS32 core. After a `start` pulse it:

- optionally initialises the register file to Reg[k] = k;
- streams a program image into instruction memory over a valid/ready port;
- clears the pipeline's PC, TAKEN_BRANCH and HALTED state, then releases the core;
- supervises execution until the core raises HALTED or a cycle budget expires.

It replaces testbench hierarchical preloading with a synthesizable load path and sits between the host/loader interface and the core's memory, register-file and control hooks.

## Interface
- MEM_AW, 10, instruction-memory address width; capacity 2^MEM_AW words
- REG_INIT, 1, 1 = run the 32-cycle register-initialisation phase; 0 = skip it
- MAX_CYCLES, 1024, run-cycle budget before timeout; legal range 1..65535

Ports:
- clk1  in  1  sole clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start request; honoured only in IDLE or DONE
- ld_valid  in  1  load word valid
- ld_ready  out  1  load word ready
- ld_data  in  32  instruction word
- ld_last  in  1  marks the final word of the image
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  MEM_AW  write address
- mem_wdata  out  32  write data
- reg_we  out  1  register-file write strobe
- reg_addr  out  5  register index
- reg_wdata  out  32  register data
- cpu_clear  out  1  one-cycle pulse; core sets PC=0, TAKEN_BRANCH=0, HALTED=0
- cpu_run  out  1  core may advance while high
- cpu_halted  in  1  core HALTED flag, raised by HLT at write-back
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- timeout  out  1  high in DONE if the budget expired
- cycle_count  out  16  RUN cycles elapsed
- words_loaded  out  MEM_AW+1  words written in the last load

## Operation
- States: IDLE, REGI, LOAD, CLEAR, RUN, DONE. All outputs are registered except ld_ready.
- Reset (asynchronous): state IDLE; every output 0; internal address and register counters 0.
- IDLE/DONE + start:
  - clear cycle_count, words_loaded, timeout and done;
  - go to REGI if REG_INIT=1, else LOAD.
- REGI: for k = 0..31, one write per cycle with reg_we=1, reg_addr=k, reg_wdata=k. After k=31, go to LOAD.
- LOAD:
  - ld_ready=1 combinationally while in LOAD.
  - Each accepted beat (ld_valid & ld_ready) writes mem[addr]=ld_data, then addr++ and words_loaded++.
  - Exit to CLEAR after the beat carrying ld_last, or after the beat written at address 2^MEM_AW-1, whichever comes first.
  - On the overflow exit, words_loaded = 2^MEM_AW and later beats are not accepted.
  - ld_valid low stalls LOAD indefinitely with no writes.
- CLEAR: cpu_clear=1 for exactly one cycle, cpu_run=0; then go to RUN.
- RUN: cpu_run=1.
  - Each edge that samples cpu_halted=0 increments cycle_count.
  - An edge that samples cpu_halted=1 goes to DONE with timeout=0 and no increment.
  - The increment that makes cycle_count equal MAX_CYCLES goes to DONE with timeout=1.
- DONE: done=1, cpu_run=0; cycle_count and words_loaded hold. start restarts from REGI (or LOAD).
- start in REGI, LOAD, CLEAR or RUN is ignored.
- ld_valid outside LOAD is ignored. cpu_halted outside RUN is ignored.

## Timing
- mem_we, mem_addr and mem_wdata are valid the cycle after the accepting edge and last one cycle per beat.
- Back-to-back beats give one write per cycle.
- reg_we writes appear on the 32 consecutive cycles following entry to REGI.
- Start to first register write: 1 cycle.
- REGI totals 32 cycles. The last beat is followed by 1 cycle of CLEAR, then cpu_run rises.
- cpu_run and busy fall in the same cycle that done rises.
- Asserting rst_n low mid-operation forces cpu_run, mem_we and reg_we low immediately, without waiting for a clock edge.
- After reset is released, a new start reloads from address 0.

## Test plan
- Reset, REG_INIT=1, start:
  - 32 register writes with data = index 0..31;
  - then load 0x2801000a, 0x28020014, 0x28030019, 0x0ce77800, 0x0ce77800, 0x00222000, 0x0ce77800, 0x00832800, 0xfc000000 (last) back-to-back;
  - required: mem writes to addr 0..8 in order, words_loaded=9, one cpu_clear pulse, cpu_run high the following cycle.
- After the above, cpu_halted asserted on the 41st RUN edge -> done=1, cycle_count=40, timeout=0, cpu_run=0.
- Random ld_valid gaps (~50%) over 9 words -> contiguous addr 0..8, no duplicate or missing writes, data matches order.
- MAX_CYCLES=64, cpu_halted held 0 -> DONE with timeout=1, cycle_count=64.
- MEM_AW=3, 10 words with no ld_last -> 8 writes (addr 0..7), words_loaded=8, ld_ready low after the 8th beat, CLEAR follows.
- rst_n low on the 4th LOAD beat -> all outputs 0 asynchronously; restart with 9 words -> first write at addr 0. A start pulse during RUN has no effect.

Source files
------------

// File: rtl/mips32_boot_ctrl.sv
// Boot-and-run sequencer for the pipelined MIPS32 core.
// After start: optional register-file init (Reg[k]=k), program image load
// over a valid/ready port, one-cycle core clear, then supervised run until
// the core halts or the cycle budget is used up.
module mips32_boot_ctrl #(
  parameter int MEM_AW     = 10,
  parameter int REG_INIT   = 1,
  parameter int MAX_CYCLES = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              reg_we,
  output logic [4:0]        reg_addr,
  output logic [31:0]       reg_wdata,
  output logic              cpu_clear,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       cycle_count,
  output logic [MEM_AW:0]   words_loaded
);

  typedef enum logic [2:0] {S_IDLE, S_REGI, S_LOAD, S_CLEAR, S_RUN, S_DONE} state_t;

  localparam logic [15:0]       MAXC     = MAX_CYCLES[15:0];
  localparam logic [MEM_AW-1:0] ADDR_TOP = {MEM_AW{1'b1}};

  state_t              r_state, w_nxt;
  logic [4:0]          r_ridx, w_ridx_nxt;
  logic [MEM_AW-1:0]   r_addr, w_addr_nxt;
  logic [15:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [MEM_AW:0]     r_wl, w_wl_nxt;
  logic                r_to, w_to_nxt;
  logic                w_mem_we, w_reg_we;
  logic [4:0]          w_reg_addr;
  logic                r_mem_we, r_reg_we, r_cpu_clear, r_cpu_run, r_busy, r_done;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [4:0]          r_reg_addr;

  assign w_cnt_inc = r_cnt + 16'd1;

  // Next-state and next-value logic; every target defaults to hold/idle first.
  always_comb begin
    w_nxt      = r_state;
    w_ridx_nxt = r_ridx;
    w_addr_nxt = r_addr;
    w_cnt_nxt  = r_cnt;
    w_wl_nxt   = r_wl;
    w_to_nxt   = r_to;
    w_mem_we   = 1'b0;
    w_reg_we   = 1'b0;
    w_reg_addr = 5'd0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_cnt_nxt  = 16'd0;
          w_wl_nxt   = '0;
          w_to_nxt   = 1'b0;
          w_addr_nxt = '0;
          w_ridx_nxt = 5'd0;
          if (REG_INIT != 0) begin
            // Register 0 is written in the first REGI cycle.
            w_nxt    = S_REGI;
            w_reg_we = 1'b1;
          end else begin
            w_nxt = S_LOAD;
          end
        end
      end
      S_REGI: begin
        if (r_ridx == 5'd31) begin
          w_nxt = S_LOAD;
        end else begin
          w_ridx_nxt = r_ridx + 5'd1;
          w_reg_we   = 1'b1;
          w_reg_addr = r_ridx + 5'd1;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          w_mem_we   = 1'b1;
          w_addr_nxt = r_addr + MEM_AW'(1);
          w_wl_nxt   = r_wl + (MEM_AW+1)'(1);
          // Stop on the tagged last word or when the top address is filled.
          if (ld_last || r_addr == ADDR_TOP) w_nxt = S_CLEAR;
        end
      end
      S_CLEAR: w_nxt = S_RUN;
      S_RUN: begin
        if (cpu_halted) begin
          w_nxt = S_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == MAXC) begin
            w_nxt    = S_DONE;
            w_to_nxt = 1'b1;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ridx      <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_wl        <= '0;
      r_to        <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_reg_addr  <= '0;
      r_cpu_clear <= 1'b0;
      r_cpu_run   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_ridx      <= w_ridx_nxt;
      r_addr      <= w_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wl        <= w_wl_nxt;
      r_to        <= w_to_nxt;
      r_mem_we    <= w_mem_we;
      if (w_mem_we) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= ld_data;
      end
      r_reg_we    <= w_reg_we;
      r_reg_addr  <= w_reg_addr;
      r_cpu_clear <= (w_nxt == S_CLEAR);
      r_cpu_run   <= (w_nxt == S_RUN);
      r_busy      <= !(w_nxt == S_IDLE || w_nxt == S_DONE);
      r_done      <= (w_nxt == S_DONE);
    end
  end

  assign ld_ready     = (r_state == S_LOAD);
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign reg_we       = r_reg_we;
  assign reg_addr     = r_reg_addr;
  assign reg_wdata    = {27'd0, r_reg_addr};
  assign cpu_clear    = r_cpu_clear;
  assign cpu_run      = r_cpu_run;
  assign busy         = r_busy;
  assign done         = r_done;
  assign timeout      = r_to;
  assign cycle_count  = r_cnt;
  assign words_loaded = r_wl;

endmodule

// File: tb/tb_mips32_boot_ctrl.sv
// Bench for mips32_boot_ctrl: default instance (A) and a small one (B,
// MEM_AW=3, no register init, 64-cycle budget). Expected writes and
// completions are queued at stimulus time and popped by a monitor.
module tb_mips32_boot_ctrl;
  logic clk1 = 1'b0, rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  logic        start_a = 0, ldv_a = 0, ldl_a = 0, hlt_a = 0;
  logic [31:0] ldd_a = 0;
  logic        ld_ready_a, mem_we_a, reg_we_a, cpu_clear_a, cpu_run_a, busy_a, done_a, timeout_a;
  logic [9:0]  mem_addr_a;
  logic [31:0] mem_wdata_a, reg_wdata_a;
  logic [4:0]  reg_addr_a;
  logic [15:0] cycle_count_a;
  logic [10:0] words_loaded_a;

  logic        start_b = 0, ldv_b = 0, ldl_b = 0, hlt_b = 0;
  logic [31:0] ldd_b = 0;
  logic        ld_ready_b, mem_we_b, reg_we_b, cpu_clear_b, cpu_run_b, busy_b, done_b, timeout_b;
  logic [2:0]  mem_addr_b;
  logic [31:0] mem_wdata_b, reg_wdata_b;
  logic [4:0]  reg_addr_b;
  logic [15:0] cycle_count_b;
  logic [3:0]  words_loaded_b;

  mips32_boot_ctrl u_a (
    .clk1(clk1), .rst_n(rst_n), .start(start_a), .ld_valid(ldv_a), .ld_ready(ld_ready_a),
    .ld_data(ldd_a), .ld_last(ldl_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .reg_we(reg_we_a), .reg_addr(reg_addr_a), .reg_wdata(reg_wdata_a),
    .cpu_clear(cpu_clear_a), .cpu_run(cpu_run_a), .cpu_halted(hlt_a), .busy(busy_a),
    .done(done_a), .timeout(timeout_a), .cycle_count(cycle_count_a), .words_loaded(words_loaded_a));

  mips32_boot_ctrl #(.MEM_AW(3), .REG_INIT(0), .MAX_CYCLES(64)) u_b (
    .clk1(clk1), .rst_n(rst_n), .start(start_b), .ld_valid(ldv_b), .ld_ready(ld_ready_b),
    .ld_data(ldd_b), .ld_last(ldl_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .reg_we(reg_we_b), .reg_addr(reg_addr_b), .reg_wdata(reg_wdata_b),
    .cpu_clear(cpu_clear_b), .cpu_run(cpu_run_b), .cpu_halted(hlt_b), .busy(busy_b),
    .done(done_b), .timeout(timeout_b), .cycle_count(cycle_count_b), .words_loaded(words_loaded_b));

  typedef struct { int addr; logic [31:0] data; } mw_t;
  typedef struct { int cnt; int to; int wl; } dn_t;

  int  rq_a[$];
  mw_t mq_a[$], mq_b[$];
  dn_t dq_a[$], dq_b[$];
  logic [31:0] img [16];
  int total = 0, bad = 0;
  int nclr_a = 0, nclr_b = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] got);
    total++;
    bad++;
    $display("FAIL %s got=0x%0h exp=nothing", nm, got);
  endtask

  // Reference model: image words land at consecutive addresses from 0,
  // truncated to memory capacity; register init writes k to Reg[k].
  task automatic expect_load(input bit b, input int n, input int cap, input bit regs);
    if (regs) for (int k = 0; k < 32; k++) rq_a.push_back(k);
    for (int i = 0; i < n && i < cap; i++) begin
      mw_t m;
      m.addr = i; m.data = img[i];
      if (b) mq_b.push_back(m); else mq_a.push_back(m);
    end
  endtask

  task automatic expect_done(input bit b, input int cnt, input int to, input int wl);
    dn_t d;
    d.cnt = cnt; d.to = to; d.wl = wl;
    if (b) dq_b.push_back(d); else dq_a.push_back(d);
  endtask

  // Monitor: compares every write/completion the DUTs present.
  mw_t m; dn_t d; int k;
  logic pclr_a = 0, pclr_b = 0, pdone_a = 0, pdone_b = 0;
  always @(negedge clk1) if (rst_n) begin
    if (reg_we_a) begin
      if (rq_a.size() == 0) flag("a_reg_extra", 32'(reg_addr_a));
      else begin
        k = rq_a.pop_front();
        chk("a_reg_addr", 32'(reg_addr_a), k);
        chk("a_reg_data", reg_wdata_a, k);
      end
    end
    if (mem_we_a) begin
      if (mq_a.size() == 0) flag("a_mem_extra", 32'(mem_addr_a));
      else begin
        m = mq_a.pop_front();
        chk("a_mem_addr", 32'(mem_addr_a), m.addr);
        chk("a_mem_data", mem_wdata_a, m.data);
      end
    end
    if (reg_we_b) flag("b_reg_extra", 32'(reg_addr_b));
    if (mem_we_b) begin
      if (mq_b.size() == 0) flag("b_mem_extra", 32'(mem_addr_b));
      else begin
        m = mq_b.pop_front();
        chk("b_mem_addr", 32'(mem_addr_b), m.addr);
        chk("b_mem_data", mem_wdata_b, m.data);
      end
    end
    if (done_a && !pdone_a) begin
      if (dq_a.size() == 0) flag("a_done_extra", 32'(cycle_count_a));
      else begin
        d = dq_a.pop_front();
        chk("a_cycle_count", 32'(cycle_count_a), d.cnt);
        chk("a_timeout", 32'(timeout_a), d.to);
        chk("a_words_loaded", 32'(words_loaded_a), d.wl);
        chk("a_run_at_done", 32'(cpu_run_a), 0);
        chk("a_busy_at_done", 32'(busy_a), 0);
      end
    end
    if (done_b && !pdone_b) begin
      if (dq_b.size() == 0) flag("b_done_extra", 32'(cycle_count_b));
      else begin
        d = dq_b.pop_front();
        chk("b_cycle_count", 32'(cycle_count_b), d.cnt);
        chk("b_timeout", 32'(timeout_b), d.to);
        chk("b_words_loaded", 32'(words_loaded_b), d.wl);
        chk("b_run_at_done", 32'(cpu_run_b), 0);
      end
    end
    if (pclr_a) begin
      chk("a_run_after_clear", 32'(cpu_run_a), 1);
      chk("a_clear_width", 32'(cpu_clear_a), 0);
    end
    if (pclr_b) chk("b_run_after_clear", 32'(cpu_run_b), 1);
    if (cpu_clear_a) begin nclr_a++; chk("a_run_in_clear", 32'(cpu_run_a), 0); end
    if (cpu_clear_b) nclr_b++;
    pclr_a = cpu_clear_a; pclr_b = cpu_clear_b;
    pdone_a = done_a; pdone_b = done_b;
  end

  task automatic drive(input bit b, input logic v, input logic [31:0] dt, input logic l);
    if (b) begin ldv_b = v; ldd_b = dt; ldl_b = l; end
    else   begin ldv_a = v; ldd_a = dt; ldl_a = l; end
  endtask

  task automatic pulse(input bit b);
    if (b) start_b = 1; else start_a = 1;
    @(posedge clk1); #1;
    start_a = 0; start_b = 0;
  endtask

  // Offer words img[first..first+n-1]; stop at the first one not taken within lim cycles.
  task automatic load(input bit b, input int first, input int n, input bit use_last,
                      input bit gaps, input int lim, output int acc);
    bit ok, stop;
    int w;
    acc = 0; stop = 0;
    for (int i = first; i < first + n && !stop; i++) begin
      if (gaps && $urandom_range(1) == 1) begin
        drive(b, 0, 32'h0, 0);
        @(posedge clk1); #1;
      end
      drive(b, 1, img[i], use_last && (i == first + n - 1));
      ok = 0; w = 0;
      while (!ok && w < lim) begin
        ok = b ? ld_ready_b : ld_ready_a;
        @(posedge clk1); #1;
        w++;
      end
      if (ok) acc++; else stop = 1;
    end
    drive(b, 0, 32'h0, 0);
  endtask

  // Halt the core on the n-th RUN edge of instance A.
  task automatic run_halt(input int n, input bit poke);
    int w = 0;
    while (!cpu_run_a && w < 200) begin @(posedge clk1); #1; w++; end
    if (!cpu_run_a) flag("a_run_wait_expired", 32'(w));
    else begin
      for (int i = 1; i < n; i++) begin
        if (poke && i == 5) start_a = 1;
        @(posedge clk1); #1;
        start_a = 0;
      end
      hlt_a = 1;
      @(posedge clk1); #1;
      hlt_a = 0;
    end
  endtask

  task automatic wait_done(input bit b, input int lim);
    int w = 0;
    while (!(b ? done_b : done_a) && w < lim) begin @(posedge clk1); #1; w++; end
    if (!(b ? done_b : done_a)) flag(b ? "b_done_wait_expired" : "a_done_wait_expired", 32'(w));
  endtask

  initial begin
    int acc, h;
    #3;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_run", 32'(cpu_run_a), 0);
    chk("rst_clear", 32'(cpu_clear_a), 0);
    chk("rst_mem_we", 32'(mem_we_a), 0);
    chk("rst_reg_we", 32'(reg_we_a), 0);
    chk("rst_ready", 32'(ld_ready_a), 0);
    chk("rst_timeout", 32'(timeout_a), 0);
    chk("rst_count", 32'(cycle_count_a), 0);
    chk("rst_words", 32'(words_loaded_a), 0);
    @(posedge clk1); #1 rst_n = 1;
    @(posedge clk1); #1;

    // Directed program with register init; halt on 41st RUN edge; start poked during RUN.
    img[0] = 32'h2801000a; img[1] = 32'h28020014; img[2] = 32'h28030019;
    img[3] = 32'h0ce77800; img[4] = 32'h0ce77800; img[5] = 32'h00222000;
    img[6] = 32'h0ce77800; img[7] = 32'h00832800; img[8] = 32'hfc000000;
    expect_load(0, 9, 1024, 1);
    expect_done(0, 40, 0, 9);
    pulse(0);
    chk("start_to_reg_write", 32'(reg_we_a), 1);
    chk("busy_after_start", 32'(busy_a), 1);
    load(0, 0, 9, 1, 0, 100, acc);
    chk("t1_accepted", 32'(acc), 9);
    chk("t1_words_loaded", 32'(words_loaded_a), 9);
    run_halt(41, 1);
    wait_done(0, 20);

    // Random image with random valid gaps, random halt point; restart from DONE.
    for (int i = 0; i < 9; i++) img[i] = $urandom;
    h = $urandom_range(60, 1);
    expect_load(0, 9, 1024, 1);
    expect_done(0, h - 1, 0, 9);
    pulse(0);
    chk("restart_count_clear", 32'(cycle_count_a), 0);
    chk("restart_done_clear", 32'(done_a), 0);
    load(0, 0, 9, 1, 1, 100, acc);
    chk("t2_accepted", 32'(acc), 9);
    run_halt(h, 0);
    wait_done(0, 20);

    // Reset asserted just after the 4th beat; outputs must drop with no clock edge.
    for (int i = 0; i < 9; i++) img[i] = $urandom;
    expect_load(0, 4, 1024, 1);
    pulse(0);
    load(0, 0, 4, 0, 0, 100, acc);
    #5 rst_n = 0;
    #1;
    chk("arst_mem_we", 32'(mem_we_a), 0);
    chk("arst_run", 32'(cpu_run_a), 0);
    chk("arst_reg_we", 32'(reg_we_a), 0);
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_ready", 32'(ld_ready_a), 0);
    chk("arst_words", 32'(words_loaded_a), 0);
    #2 rst_n = 1;
    @(posedge clk1); #1;
    h = $urandom_range(30, 1);
    expect_load(0, 9, 1024, 1);
    expect_done(0, h - 1, 0, 9);
    pulse(0);
    load(0, 0, 9, 1, 0, 100, acc);
    chk("t3_accepted", 32'(acc), 9);
    run_halt(h, 0);
    wait_done(0, 20);

    // Small instance: 10 words without last into 8-word memory, then budget timeout.
    for (int i = 0; i < 10; i++) img[i] = $urandom;
    expect_load(1, 10, 8, 0);
    expect_done(1, 64, 1, 8);
    pulse(1);
    load(1, 0, 8, 0, 0, 20, acc);
    chk("b_accepted", 32'(acc), 8);
    chk("b_ready_after_full", 32'(ld_ready_b), 0);
    chk("b_words_after_full", 32'(words_loaded_b), 8);
    chk("b_clear_after_full", 32'(cpu_clear_b), 1);
    load(1, 8, 2, 0, 0, 5, acc);
    chk("b_extra_accepted", 32'(acc), 0);
    wait_done(1, 200);

    @(posedge clk1); #1;
    chk("a_reg_q_left", 32'(rq_a.size()), 0);
    chk("a_mem_q_left", 32'(mq_a.size()), 0);
    chk("a_done_q_left", 32'(dq_a.size()), 0);
    chk("b_mem_q_left", 32'(mq_b.size()), 0);
    chk("b_done_q_left", 32'(dq_b.size()), 0);
    chk("a_clear_pulses", 32'(nclr_a), 3);
    chk("b_clear_pulses", 32'(nclr_b), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
